// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes and the bit-reversal helper used by
// the kernel stages and the output reorder stage.
package fft_pkg;

  localparam int unsigned FFT_N_DEF    = 8;
  localparam int unsigned FFT_DW_DEF   = 16;
  localparam int unsigned FFT_LOGN_DEF = $clog2(FFT_N_DEF);

  // Reverse the low 'bits' bits of p.
  function automatic int unsigned bitrev(input int unsigned p, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) begin
      r = (r << 1) | ((p >> i) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame buffer: a dual write port into one bank per cycle and an
// asynchronous read port, so the writer and reader can work on different banks.
module fft_pingpong_ram
  import fft_pkg::*;
#(
  parameter int unsigned N = FFT_N_DEF,
  parameter int unsigned W = 2 * FFT_DW_DEF
) (
  input  logic                 clk_i,
  input  logic                 i_wr_en,
  input  logic                 i_wr_bank,
  input  logic [$clog2(N)-1:0] i_wr_addr0,
  input  logic [W-1:0]         i_wr_data0,
  input  logic [$clog2(N)-1:0] i_wr_addr1,
  input  logic [W-1:0]         i_wr_data1,
  input  logic                 i_rd_bank,
  input  logic [$clog2(N)-1:0] i_rd_addr,
  output logic [W-1:0]         o_rd_data
);

  logic [W-1:0] r_mem [2][N];

  always_ff @(posedge clk_i) begin
    if (i_wr_en) begin
      r_mem[i_wr_bank][i_wr_addr0] <= i_wr_data0;
      r_mem[i_wr_bank][i_wr_addr1] <= i_wr_data1;
    end
  end

  assign o_rd_data = r_mem[i_rd_bank][i_rd_addr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// FFT output stage: collects a bit-reversed frame (two samples per beat) into a
// ping-pong buffer and streams it out in natural bin order, one sample per beat.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int unsigned N  = FFT_N_DEF,
  parameter int unsigned DW = FFT_DW_DEF
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DW-1:0]        X1_real_i,
  input  logic [DW-1:0]        X1_imag_i,
  input  logic [DW-1:0]        X2_real_i,
  input  logic [DW-1:0]        X2_imag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DW-1:0]        out_real_o,
  output logic [DW-1:0]        out_imag_o,
  output logic [$clog2(N)-1:0] out_index_o,
  output logic                 out_last_o
);

  localparam int unsigned LOGN = $clog2(N);
  localparam int unsigned CW   = LOGN - 1;
  localparam logic [LOGN-1:0] LAST_BIN = LOGN'(N - 1);

  logic [CW-1:0]   r_wr_cnt;
  logic [LOGN-1:0] r_rd_cnt;
  logic            r_wr_sel;
  logic            r_rd_sel;
  logic [1:0]      r_bank_full;
  logic            r_out_valid;
  logic [DW-1:0]   r_out_real;
  logic [DW-1:0]   r_out_imag;
  logic [LOGN-1:0] r_out_index;
  logic            r_out_last;

  logic            w_in_ready;
  logic            w_in_fire;
  logic            w_wr_last;
  logic            w_load;
  logic            w_rd_last;
  logic [LOGN-1:0] w_wr_addr0;
  logic [LOGN-1:0] w_wr_addr1;
  logic [2*DW-1:0] w_rd_data;
  logic [1:0]      w_bank_full_nxt;

  assign w_in_ready = !r_bank_full[r_wr_sel];
  assign w_in_fire  = in_valid_i && w_in_ready;
  assign w_wr_last  = (r_wr_cnt == '1);
  // Stream positions 2k and 2k+1 land at their bit-reversed bin addresses.
  assign w_wr_addr0 = LOGN'(bitrev(32'({r_wr_cnt, 1'b0}), LOGN));
  assign w_wr_addr1 = LOGN'(bitrev(32'({r_wr_cnt, 1'b1}), LOGN));
  assign w_load     = r_bank_full[r_rd_sel] && (!r_out_valid || out_ready_i);
  assign w_rd_last  = (r_rd_cnt == LAST_BIN);

  fft_pingpong_ram #(
    .N (N),
    .W (2 * DW)
  ) u_ram (
    .clk_i      (clk_i),
    .i_wr_en    (w_in_fire),
    .i_wr_bank  (r_wr_sel),
    .i_wr_addr0 (w_wr_addr0),
    .i_wr_data0 ({X1_real_i, X1_imag_i}),
    .i_wr_addr1 (w_wr_addr1),
    .i_wr_data1 ({X2_real_i, X2_imag_i}),
    .i_rd_bank  (r_rd_sel),
    .i_rd_addr  (r_rd_cnt),
    .o_rd_data  (w_rd_data)
  );

  // Writer and reader only ever touch different banks here, so both updates apply.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_in_fire && w_wr_last) w_bank_full_nxt[r_wr_sel] = 1'b1;
    if (w_load && w_rd_last)    w_bank_full_nxt[r_rd_sel] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_bank_full <= '0;
      r_out_valid <= 1'b0;
      r_out_real  <= '0;
      r_out_imag  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_bank_full <= w_bank_full_nxt;
      if (w_in_fire) begin
        r_wr_cnt <= r_wr_cnt + CW'(1);
        if (w_wr_last) r_wr_sel <= !r_wr_sel;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_real  <= w_rd_data[2*DW-1:DW];
        r_out_imag  <= w_rd_data[DW-1:0];
        r_out_index <= r_rd_cnt;
        r_out_last  <= w_rd_last;
        r_rd_cnt    <= r_rd_cnt + LOGN'(1);
        if (w_rd_last) r_rd_sel <= !r_rd_sel;
      end else if (r_out_valid && out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_real_o  = r_out_real;
  assign out_imag_o  = r_out_imag;
  assign out_index_o = r_out_index;
  assign out_last_o  = r_out_last;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: frames are built in natural order,
// sent in bit-reversed pairs, and outputs are compared against an expected queue.
module tb_fft_bitrev_reorder;

  localparam int N    = 8;
  localparam int DW   = 16;
  localparam int LOGN = 3;

  typedef struct {
    logic [DW-1:0]   re;
    logic [DW-1:0]   im;
    logic [LOGN-1:0] idx;
    logic            last;
  } exp_t;

  logic            clk;
  logic            rstn;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   x1r, x1i, x2r, x2i;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_real;
  logic [DW-1:0]   out_imag;
  logic [LOGN-1:0] out_index;
  logic            out_last;

  exp_t          exp_q[$];
  int            n_tests;
  int            n_fail;
  logic [DW-1:0] fr_re [N];
  logic [DW-1:0] fr_im [N];
  int            gaps;
  bit            seen;

  fft_bitrev_reorder #(
    .N  (N),
    .DW (DW)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .X1_real_i   (x1r),
    .X1_imag_i   (x1i),
    .X2_real_i   (x2r),
    .X2_imag_i   (x2i),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_real_o  (out_real),
    .out_imag_o  (out_imag),
    .out_index_o (out_index),
    .out_last_o  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tb_bitrev(int p);
    int r;
    r = 0;
    for (int i = 0; i < LOGN; i++) begin
      r = r * 2 + (p % 2);
      p = p / 2;
    end
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic monitor_loop();
    exp_t          e;
    logic          stall;
    logic [DW-1:0] pr, pi;
    logic [LOGN-1:0] px;
    logic          pl;
    stall = 1'b0;
    pr = '0; pi = '0; px = '0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_real",  out_real,  pr);
        check("hold_imag",  out_imag,  pi);
        check("hold_index", out_index, px);
        check("hold_last",  out_last,  pl);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("out_real",  out_real,  e.re);
          check("out_imag",  out_imag,  e.im);
          check("out_index", out_index, e.idx);
          check("out_last",  out_last,  e.last);
        end
      end
      stall = out_valid && !out_ready;
      pr = out_real; pi = out_imag; px = out_index; pl = out_last;
    end
  endtask

  task automatic send_beat(int k);
    bit acc;
    in_valid = 1'b1;
    x1r = fr_re[tb_bitrev(2 * k)];
    x1i = fr_im[tb_bitrev(2 * k)];
    x2r = fr_re[tb_bitrev(2 * k + 1)];
    x2i = fr_im[tb_bitrev(2 * k + 1)];
    acc = 1'b0;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("beat_timeout", 0, 1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame();
    exp_t e;
    for (int b = 0; b < N; b++) begin
      e.re = fr_re[b];
      e.im = fr_im[b];
      e.idx = LOGN'(b);
      e.last = (b == N - 1);
      exp_q.push_back(e);
    end
    for (int k = 0; k < N / 2; k++) send_beat(k);
  endtask

  task automatic rand_frame();
    for (int b = 0; b < N; b++) begin
      fr_re[b] = DW'($urandom);
      fr_im[b] = DW'($urandom);
    end
  endtask

  task automatic drain(string tag);
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(negedge clk);
    check(tag, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rstn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x1r = '0; x1i = '0; x2r = '0; x2i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_real",  out_real,  0);
    check("rst_imag",  out_imag,  0);
    check("rst_index", out_index, 0);
    check("rst_last",  out_last,  0);
    check("rst_ready", in_ready,  1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    fork
      monitor_loop();
    join_none

    // 1: ramp frame, bins 100..107 / -100..-107
    out_ready = 1'b1;
    for (int b = 0; b < N; b++) begin
      fr_re[b] = DW'(100 + b);
      fr_im[b] = DW'(-(100 + b));
    end
    check("pre_valid", out_valid, 0);
    send_frame();
    check("latency_valid", out_valid, 1);
    check("latency_index", out_index, 0);
    drain("drain_ramp");

    // 2: back-to-back frames must stream without gaps
    fork
      begin
        rand_frame();
        send_frame();
        rand_frame();
        send_frame();
      end
      begin
        gaps = 0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
          @(negedge clk);
          seen = out_valid;
        end
        if (!seen) begin
          check("stream_start", 0, 1);
        end else begin
          for (int c = 0; c < 2 * N - 1; c++) begin
            @(negedge clk);
            if (!out_valid) gaps++;
          end
          check("stream_gaps", gaps, 0);
        end
      end
    join
    drain("drain_stream");

    // 3: downstream stalled while two frames arrive; blocked beats are ignored
    out_ready = 1'b0;
    rand_frame();
    send_frame();
    rand_frame();
    send_frame();
    @(negedge clk);
    check("in_ready_full", in_ready, 0);
    in_valid = 1'b1;
    x1r = DW'($urandom); x1i = DW'($urandom);
    x2r = DW'($urandom); x2i = DW'($urandom);
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_held", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("drain_stalled");

    // 4: downstream ready toggling every cycle
    out_ready = 1'b0;
    rand_frame();
    fork
      send_frame();
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    drain("drain_toggle");

    // 5: reset mid-frame discards everything buffered
    out_ready = 1'b0;
    rand_frame();
    send_frame();
    rand_frame();
    send_beat(0);
    send_beat(1);
    #2;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_real",  out_real,  0);
    check("mid_rst_imag",  out_imag,  0);
    check("mid_rst_index", out_index, 0);
    check("mid_rst_last",  out_last,  0);
    check("mid_rst_ready", in_ready,  1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    rand_frame();
    send_frame();
    drain("drain_after_rst");

    // 6: extreme component values pass through untouched
    for (int b = 0; b < N; b++) begin
      fr_re[b] = (b % 2 == 0) ? 16'h8000 : 16'h7FFF;
      fr_im[b] = (b % 2 == 0) ? 16'h7FFF : 16'h8000;
    end
    send_frame();
    drain("drain_extreme");

    check("final_queue", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
